// File: rtl/spi_sensor_responder_if.sv
// SPI bus between the parking-meter controller (master) and the sensor stand-in (slave).
interface spi_sensor_responder_if;
  logic SS;       // slave select, active-low
  logic SCLK;     // idles low (mode 0)
  logic MOSI;
  logic MISO;
  logic miso_oe;  // MISO is only meaningful while this is high

  modport master (
    output SS,
    output SCLK,
    output MOSI,
    input  MISO,
    input  miso_oe
  );

  modport slave (
    input  SS,
    input  SCLK,
    input  MOSI,
    output MISO,
    output miso_oe
  );
endinterface

// File: rtl/spi_sensor_responder.sv
// Mode-0 SPI slave that stands in for the distance sensor: serves {zeros, sample} MSB first
// and captures the master's MOSI frame. All SPI pins are oversampled in the clk domain.
module spi_sensor_responder #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_wr,
  spi_sensor_responder_if.slave spi,
  output logic                  busy,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  overrun
);

  localparam int unsigned CntW = $clog2(FRAME_BITS) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);

  typedef enum logic [1:0] {StIdle, StActive, StOverrun} state_e;

  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   ss_prev_q, sclk_prev_q;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [DATA_W-1:0]      hold_q;
  state_e                 state_q;
  logic [FRAME_BITS-1:0]  tx_shift_q, rx_shift_q, rx_data_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic                   miso_q, oe_q, done_q, abort_q, overrun_q;

  // Synchronizers plus one edge-detect flop per line. SS resets low so that a reset taken
  // mid-frame does not fabricate a falling edge once SS is seen low again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.SS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // Holding register; writable in any state, only sampled at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (sample_wr) begin
      hold_q <= sample_in;
    end
  end

  // Frame FSM with registered outputs. SS edges are tested first so a coincident SCLK
  // edge is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            tx_shift_q <= FRAME_BITS'(hold_q);
            miso_q     <= FRAME_BITS'(hold_q) >> (FRAME_BITS - 1) != '0;
            oe_q       <= 1'b1;
            bit_cnt_q  <= '0;
            overrun_q  <= 1'b0;
            state_q    <= StActive;
          end
        end
        StActive: begin
          if (ss_rise) begin
            if (bit_cnt_q == CntFull) begin
              rx_data_q <= rx_shift_q;
              done_q    <= 1'b1;
            end else begin
              abort_q <= 1'b1;
            end
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            state_q <= StIdle;
          end else if (sclk_rise) begin
            if (bit_cnt_q == CntFull) begin
              overrun_q <= 1'b1;
              miso_q    <= 1'b0;
              state_q   <= StOverrun;
            end else begin
              rx_shift_q <= {rx_shift_q[FRAME_BITS-2:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + CntW'(1);
            end
          end else if (sclk_fall) begin
            // Zero fill drives MISO low once the last bit has gone out.
            tx_shift_q <= tx_shift_q << 1;
            miso_q     <= tx_shift_q[FRAME_BITS-2];
          end
        end
        StOverrun: begin
          miso_q <= 1'b0;
          if (ss_rise) begin
            oe_q    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi.MISO    = miso_q;
  assign spi.miso_oe = oe_q;
  assign busy        = (state_q != StIdle);
  assign rx_data     = rx_data_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Bench for spi_sensor_responder: directed frame table, hand-written reset and idle-bus
// sequences, then randomized frames checked against a frame-level reference model.
module tb_spi_sensor_responder;

  logic        clk;
  logic        rst;
  logic [11:0] sample_in;
  logic        sample_wr;
  logic        busy;
  logic [15:0] rx_data;
  logic        frame_done;
  logic        frame_abort;
  logic        overrun;

  spi_sensor_responder_if bus ();

  spi_sensor_responder #(
    .FRAME_BITS  (16),
    .DATA_W      (12),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_wr   (sample_wr),
    .spi         (bus),
    .busy        (busy),
    .rx_data     (rx_data),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int done_cnt;
  int abort_cnt;
  int both_cnt;

  // Pulse monitor: a pulse lasting two cycles counts twice.
  always @(posedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_abort) abort_cnt++;
    if (frame_done && frame_abort) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_sample(input logic [11:0] v);
    sample_in = v;
    sample_wr = 1'b1;
    clks(1);
    sample_wr = 1'b0;
    clks(1);
  endtask

  // One SS-framed transfer of nbits SCLK cycles (SCLK half period = 8 clk).
  task automatic run_frame(input int nbits, input logic [15:0] mosi_w, input bit mid_wr,
                           input logic [11:0] mid_s, input logic [15:0] exp_frame,
                           input int exp_done, input int exp_abort, input bit exp_ovr,
                           input logic [15:0] exp_rx);
    int d0, a0;
    logic exp_bit;
    d0 = done_cnt;
    a0 = abort_cnt;
    bus.SS = 1'b0;
    clks(8);
    check("oe_on", {31'd0, bus.miso_oe}, 32'd1);
    check("busy_on", {31'd0, busy}, 32'd1);
    check("ovr_clr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) bus.MOSI = mosi_w[15-i];
      else bus.MOSI = 1'($urandom_range(0, 1));
      clks(4);
      exp_bit = 1'b0;
      if (i < 16) exp_bit = exp_frame[15-i];
      if (bus.MISO !== exp_bit)
        check($sformatf("miso_bit%0d", i), {31'd0, bus.MISO}, {31'd0, exp_bit});
      else tests_run++;
      bus.SCLK = 1'b1;
      clks(8);
      if (mid_wr && i == 5) begin
        sample_in = mid_s;
        sample_wr = 1'b1;
        clks(1);
        sample_wr = 1'b0;
      end
      bus.SCLK = 1'b0;
      clks(4);
    end
    clks(4);
    bus.SS = 1'b1;
    clks(8);
    check("done_cnt", done_cnt - d0, exp_done);
    check("abort_cnt", abort_cnt - a0, exp_abort);
    check("oe_off", {31'd0, bus.miso_oe}, 32'd0);
    check("miso_off", {31'd0, bus.MISO}, 32'd0);
    check("busy_off", {31'd0, busy}, 32'd0);
    check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    check("rx_data", {16'd0, rx_data}, {16'd0, exp_rx});
  endtask

  typedef struct {
    int          nbits;
    bit          pre_wr;
    logic [11:0] pre_s;
    logic [15:0] mosi;
    bit          mid_wr;
    logic [11:0] mid_s;
    logic [15:0] exp_frame;
    int          exp_done;
    int          exp_abort;
    bit          exp_ovr;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  // Frame-level reference model state.
  logic [11:0] m_hold;
  logic [15:0] m_rx;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    done_cnt     = 0;
    abort_cnt    = 0;
    both_cnt     = 0;
    rst          = 1'b1;
    sample_in    = '0;
    sample_wr    = 1'b0;
    bus.SS       = 1'b1;
    bus.SCLK     = 1'b0;
    bus.MOSI     = 1'b0;

    vecs[0] = '{16, 1'b1, 12'hABC, 16'h5A3C, 1'b0, 12'h000, 16'h0ABC, 1, 0, 1'b0, 16'h5A3C};
    vecs[1] = '{16, 1'b1, 12'h456, 16'h1234, 1'b1, 12'h123, 16'h0456, 1, 0, 1'b0, 16'h1234};
    vecs[2] = '{16, 1'b0, 12'h000, 16'h8001, 1'b0, 12'h000, 16'h0123, 1, 0, 1'b0, 16'h8001};
    vecs[3] = '{9,  1'b0, 12'h000, 16'hFFFF, 1'b0, 12'h000, 16'h0123, 0, 1, 1'b0, 16'h8001};
    vecs[4] = '{20, 1'b0, 12'h000, 16'h0F0F, 1'b0, 12'h000, 16'h0123, 0, 0, 1'b1, 16'h8001};
    vecs[5] = '{16, 1'b1, 12'hFED, 16'h7E7E, 1'b0, 12'h000, 16'h0FED, 1, 0, 1'b0, 16'h7E7E};

    clks(3);
    check("reset_outs", {26'd0, bus.MISO, bus.miso_oe, busy, frame_done, frame_abort, overrun},
          32'd0);
    check("reset_rx", {16'd0, rx_data}, 32'd0);
    rst = 1'b0;
    clks(3);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_wr) write_sample(vecs[v].pre_s);
      run_frame(vecs[v].nbits, vecs[v].mosi, vecs[v].mid_wr, vecs[v].mid_s,
                vecs[v].exp_frame, vecs[v].exp_done, vecs[v].exp_abort, vecs[v].exp_ovr,
                vecs[v].exp_rx);
    end

    // SCLK/MOSI activity with SS high is ignored.
    begin
      int d0, a0;
      d0 = done_cnt;
      a0 = abort_cnt;
      for (int i = 0; i < 16; i++) begin
        bus.MOSI = 1'(i);
        bus.SCLK = 1'b1;
        clks(8);
        bus.SCLK = 1'b0;
        clks(8);
      end
      check("ssh_busy", {31'd0, busy}, 32'd0);
      check("ssh_oe", {31'd0, bus.miso_oe}, 32'd0);
      check("ssh_pulses", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
      check("ssh_rx", {16'd0, rx_data}, 32'h7E7E);
    end

    // Reset after bit 8 with SS low and SCLK still running.
    begin
      int d0, a0;
      bus.SS = 1'b0;
      clks(8);
      for (int i = 0; i < 8; i++) begin
        bus.MOSI = 1'b1;
        clks(4);
        bus.SCLK = 1'b1;
        clks(8);
        bus.SCLK = 1'b0;
        clks(4);
      end
      rst = 1'b1;
      #1;
      check("arst_outs", {26'd0, bus.MISO, bus.miso_oe, busy, frame_done, frame_abort, overrun},
            32'd0);
      check("arst_rx", {16'd0, rx_data}, 32'd0);
      clks(2);
      rst = 1'b0;
      d0 = done_cnt;
      a0 = abort_cnt;
      for (int i = 0; i < 8; i++) begin
        clks(4);
        bus.SCLK = 1'b1;
        clks(8);
        bus.SCLK = 1'b0;
        clks(4);
        if (i == 3) check("arst_idle", {30'd0, busy, bus.miso_oe}, 32'd0);
      end
      clks(4);
      bus.SS = 1'b1;
      clks(8);
      check("arst_nopulse", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
      check("arst_rx_hold", {16'd0, rx_data}, 32'd0);
      // Fresh frame after reset; holding register was cleared.
      run_frame(16, 16'hC3A5, 1'b0, 12'h000, 16'h0000, 1, 0, 1'b0, 16'hC3A5);
    end

    // Randomized frames against the frame-level model.
    m_hold = 12'h000;
    m_rx   = 16'hC3A5;
    for (int n = 0; n < 20; n++) begin
      int          nb;
      bit          mw;
      logic [11:0] ms;
      logic [15:0] mo;
      logic [15:0] frame;
      if ($urandom_range(0, 1) == 1) begin
        ms = 12'($urandom);
        write_sample(ms);
        m_hold = ms;
      end
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : 16;
      mw = 1'($urandom_range(0, 1));
      ms = 12'($urandom);
      mo = 16'($urandom);
      frame = {4'h0, m_hold};
      if (mw && nb > 5) m_hold = ms;
      if (nb == 16) m_rx = mo;
      run_frame(nb, mo, mw, ms, frame, (nb == 16) ? 1 : 0, (nb < 16) ? 1 : 0, nb > 16, m_rx);
    end

    check("pulse_overlap", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
